// File: rtl/trig_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : trig_pkg                                               |
// | Description : Shared FSM state encoding and edge-mode encodings for  |
// |               the external trigger generator.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package trig_pkg;

  // One-hot trigger FSM states
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_DELAY   = 4'b0010,
    ST_PULSE   = 4'b0100,
    ST_HOLDOFF = 4'b1000
  } trig_state_e;

  // Bit positions inside the one-hot state vector
  localparam int c_IDLE_BIT  = 0;
  localparam int c_PULSE_BIT = 2;

  // i_edge_mode encodings
  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_NONE = 2'b11;

  // Turns rise/fall strobes into a single qualified-edge strobe
  function automatic logic edge_qualify(input logic [1:0] mode,
                                        input logic       rise,
                                        input logic       fall);
    logic q;
    q = 1'b0;
    case (mode)
      EDGE_RISE: q = rise;
      EDGE_FALL: q = fall;
      EDGE_BOTH: q = rise | fall;
      EDGE_NONE: q = 1'b0;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trig_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : trig_filter                                            |
// | Description : 2-flop synchroniser, stability glitch filter and       |
// |               rise/fall edge strobes for the external trigger.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module trig_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic i_clk100M,
  input  logic i_rst_n,
  input  logic trig_i,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(FILT_LEN - 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          filt_prev_q;
  logic [CW-1:0] stab_q, stab_d;

  // Bring the asynchronous trigger into the clock domain
  always_ff @(posedge i_clk100M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= trig_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles the synchronised level differs from the filtered one
  always_comb begin
    filt_d = filt_q;
    stab_d = '0;
    if (sync2_q != filt_q) begin
      if (stab_q == c_LAST) begin
        filt_d = sync2_q;
      end else begin
        stab_d = stab_q + CW'(1);
      end
    end
  end

  // Filtered level, its previous value and the stability counter
  always_ff @(posedge i_clk100M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      stab_q      <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      stab_q      <= stab_d;
    end
  end

  assign rise_o = filt_q & ~filt_prev_q;
  assign fall_o = ~filt_q & filt_prev_q;

endmodule
`default_nettype wire

// File: rtl/ext_trig_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ext_trig_gen                                           |
// | Description : Filtered external trigger -> delayed, width-controlled |
// |               pulse with holdoff, plus accept/miss counters.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ext_trig_gen #(
  parameter int DELAY_W  = 16,
  parameter int PULSE_W  = 8,
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 16
) (
  input  logic               i_clk100M,
  input  logic               i_rst_n,
  input  logic               i_trig_in,
  input  logic               i_enable,
  input  logic [1:0]         i_edge_mode,
  input  logic [DELAY_W-1:0] i_delay,
  input  logic [PULSE_W-1:0] i_pulse_w,
  input  logic [DELAY_W-1:0] i_holdoff,
  input  logic               i_cnt_clr,
  output logic               o_trig_recv,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_trig_cnt,
  output logic [CNT_W-1:0]   o_miss_cnt
);

  import trig_pkg::*;

  // One timer serves delay, pulse and holdoff, so it spans the wider field
  localparam int TW = (DELAY_W > PULSE_W) ? DELAY_W : PULSE_W;

  trig_state_e        state_q, state_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [PULSE_W-1:0] pw_q, pw_d;
  logic [DELAY_W-1:0] ho_q, ho_d;
  logic [CNT_W-1:0]   trig_cnt_q, trig_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic               rise, fall, qual, accept, miss;

  trig_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .i_clk100M (i_clk100M),
    .i_rst_n   (i_rst_n),
    .trig_i    (i_trig_in),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  assign qual = edge_qualify(i_edge_mode, rise, fall);

  // Next-state, timer reload/decrement and configuration latch
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pw_d    = pw_q;
    ho_d    = ho_q;
    accept  = 1'b0;
    miss    = 1'b0;
    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (qual) begin
            accept = 1'b1;
            pw_d   = i_pulse_w;
            ho_d   = i_holdoff;
            // A delay of 0 or 1 means the pulse starts on the very next cycle
            if ((i_delay == '0) || (i_delay == DELAY_W'(1))) begin
              state_d = ST_PULSE;
              tmr_d   = TW'(i_pulse_w);
            end else begin
              state_d = ST_DELAY;
              tmr_d   = TW'(i_delay) - TW'(1);
            end
          end
        end
        ST_DELAY: begin
          miss = qual;
          if (tmr_q == TW'(1)) begin
            state_d = ST_PULSE;
            tmr_d   = TW'(pw_q);
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        ST_PULSE: begin
          miss = qual;
          // Width 0 behaves as width 1
          if ((tmr_q == '0) || (tmr_q == TW'(1))) begin
            if (ho_q == '0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_HOLDOFF;
              tmr_d   = TW'(ho_q);
            end
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        ST_HOLDOFF: begin
          miss = qual;
          if (tmr_q == TW'(1)) begin
            state_d = ST_IDLE;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Saturating counters; a clear wins over a coincident increment
  always_comb begin
    trig_cnt_d = trig_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept && (trig_cnt_q != '1)) trig_cnt_d = trig_cnt_q + CNT_W'(1);
    if (miss && (miss_cnt_q != '1))   miss_cnt_d = miss_cnt_q + CNT_W'(1);
    if (i_cnt_clr) begin
      trig_cnt_d = '0;
      miss_cnt_d = '0;
    end
  end

  // State, timer, latched configuration and counter registers
  always_ff @(posedge i_clk100M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      pw_q       <= '0;
      ho_q       <= '0;
      trig_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      pw_q       <= pw_d;
      ho_q       <= ho_d;
      trig_cnt_q <= trig_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Outputs come straight from one-hot state flops
  assign o_trig_recv = state_q[c_PULSE_BIT];
  assign o_busy      = ~state_q[c_IDLE_BIT];
  assign o_trig_cnt  = trig_cnt_q;
  assign o_miss_cnt  = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_trig_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ext_trig_gen                                        |
// | Description : Scoreboard bench for ext_trig_gen with a cycle-indexed |
// |               behavioural reference model.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ext_trig_gen;

  localparam int DW   = 16;
  localparam int PW   = 8;
  localparam int FL   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trig_in = 1'b0;
  logic          enable = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [1:0]    edge_mode = 2'b00;
  logic [DW-1:0] delay = '0;
  logic [PW-1:0] pulse_w = '0;
  logic [DW-1:0] holdoff = '0;
  logic          trig_recv, busy;
  logic [CW-1:0] trig_cnt, miss_cnt;

  ext_trig_gen #(
    .DELAY_W (DW), .PULSE_W (PW), .FILT_LEN (FL), .CNT_W (CW)
  ) dut (
    .i_clk100M   (clk),
    .i_rst_n     (rst_n),
    .i_trig_in   (trig_in),
    .i_enable    (enable),
    .i_edge_mode (edge_mode),
    .i_delay     (delay),
    .i_pulse_w   (pulse_w),
    .i_holdoff   (holdoff),
    .i_cnt_clr   (cnt_clr),
    .o_trig_recv (trig_recv),
    .o_busy      (busy),
    .o_trig_cnt  (trig_cnt),
    .o_miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  typedef struct { int cyc; bit busy; int tc; int mc; } exp_t;
  typedef struct { int start; int width; } pulse_t;
  exp_t   exp_q[$];
  pulse_t pulse_q[$];

  // Reference model: input sample history, filtered level, busy window, counts
  bit smp[$];
  bit f_now, f_prev, m_rise, m_fall;
  int idle_at, cur_ps, cur_pe, m_tc, m_mc;

  function automatic void check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  function automatic void model_reset();
    smp.delete();
    for (int k = 0; k < FL + 2; k++) smp.push_back(1'b0);
    f_now = 0; f_prev = 0; m_rise = 0; m_fall = 0;
    idle_at = 0; cur_ps = -1; cur_pe = -1; m_tc = 0; m_mc = 0;
    exp_q.delete();
    pulse_q.delete();
  endfunction

  function automatic bit model_qual();
    case (edge_mode)
      2'd0:    return m_rise;
      2'd1:    return m_fall;
      2'd2:    return m_rise | m_fall;
      default: return 1'b0;
    endcase
  endfunction

  // Filtered level follows the input once the last FL synchronised samples agree
  function automatic void model_filter();
    bit v, same;
    int n;
    n    = smp.size();
    v    = smp[n-3];
    same = 1'b1;
    for (int k = 0; k < FL; k++) if (smp[n-3-k] != v) same = 1'b0;
    f_prev = f_now;
    if (same) f_now = v;
    m_rise = f_now & ~f_prev;
    m_fall = ~f_now & f_prev;
  endfunction

  // Decide what the clock edge ending this cycle does, and queue expectations
  function automatic void model_commit();
    int j, d, p;
    exp_t   e;
    pulse_t pl;
    j = cyc;
    if (!enable) begin
      if (idle_at > j + 1) idle_at = j + 1;
      if (cur_pe >= j + 1 && pulse_q.size() > 0) begin
        pl = pulse_q.pop_back();
        if (cur_ps < j + 1) begin
          pl.width = j + 1 - cur_ps;
          pulse_q.push_back(pl);
        end
        cur_pe = j;
      end
    end else if (model_qual()) begin
      if (j >= idle_at) begin
        d = (int'(delay) <= 1) ? 1 : int'(delay);
        p = (pulse_w == 0) ? 1 : int'(pulse_w);
        cur_ps  = j + d;
        cur_pe  = cur_ps + p - 1;
        idle_at = cur_pe + 1 + int'(holdoff);
        pl.start = cur_ps;
        pl.width = p;
        pulse_q.push_back(pl);
        if (m_tc < CMAX) m_tc++;
      end else if (m_mc < CMAX) begin
        m_mc++;
      end
    end
    if (cnt_clr) begin
      m_tc = 0;
      m_mc = 0;
    end
    e.cyc  = j + 1;
    e.busy = (j + 1 < idle_at);
    e.tc   = m_tc;
    e.mc   = m_mc;
    exp_q.push_back(e);
    smp.push_back(trig_in);
    void'(smp.pop_front());
  endfunction

  task automatic cycle();
    model_commit();
    @(posedge clk);
    cyc++;
    #1;
    model_filter();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    while (!model_qual() && n < 40) begin
      cycle();
      n++;
    end
    if (n >= 40) check({tag, "_strobe_timeout"}, n, 0);
  endtask

  // Monitor: pops expectations and compares whatever the DUT presents
  exp_t   me;
  pulse_t mp;
  bit     prev_tr = 1'b0;
  int     st = 0;
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_tr = 1'b0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        me = exp_q.pop_front();
        check("busy", int'(busy), int'(me.busy));
        check("trig_cnt", int'(trig_cnt), me.tc);
        check("miss_cnt", int'(miss_cnt), me.mc);
      end
      if (trig_recv && !prev_tr) st = cyc;
      if (!trig_recv && prev_tr) begin
        if (pulse_q.size() == 0) begin
          check("unexpected_pulse_start", st, -1);
        end else begin
          mp = pulse_q.pop_front();
          check("pulse_start", st, mp.start);
          check("pulse_width", cyc - st, mp.width);
        end
      end
      prev_tr = trig_recv;
    end
  end

  initial begin
    int hold;
    hold = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_trig_recv", int'(trig_recv), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_trig_cnt", int'(trig_cnt), 0);
    check("rst_miss_cnt", int'(miss_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    model_reset();
    mon_en = 1'b1;
    enable = 1'b1;

    // Rising mode, D=5 P=3 H=0, clean step
    edge_mode = 2'b00; delay = DW'(5); pulse_w = PW'(3); holdoff = '0;
    run(10);
    trig_in = 1'b1;
    wait_strobe("step");
    cycle();
    run(20);
    check("step_trig_cnt", int'(trig_cnt), 1);
    trig_in = 1'b0;
    run(12);

    // 3-cycle glitch is filtered out
    trig_in = 1'b1;
    run(3);
    trig_in = 1'b0;
    run(15);
    check("glitch_trig_cnt", int'(trig_cnt), 1);
    check("glitch_miss_cnt", int'(miss_cnt), 0);

    // Both edges, D=0 P=1 H=10, toggling every 4 cycles
    edge_mode = 2'b10; delay = '0; pulse_w = PW'(1); holdoff = DW'(10);
    for (int t = 0; t < 8; t++) begin
      trig_in = ~trig_in;
      run(4);
    end
    run(25);

    // Counter saturation, then clear coinciding with an accept
    edge_mode = 2'b00; delay = DW'(1); pulse_w = PW'(1); holdoff = '0;
    trig_in = 1'b0;
    run(10);
    for (int t = 0; t < 20; t++) begin
      trig_in = 1'b1;
      run(8);
      trig_in = 1'b0;
      run(8);
    end
    check("sat_trig_cnt", int'(trig_cnt), CMAX);
    trig_in = 1'b1;
    wait_strobe("clr");
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    run(3);
    check("clr_trig_cnt", int'(trig_cnt), 0);
    trig_in = 1'b0;
    run(10);

    // D=100, enable dropped 50 cycles after the strobe
    delay = DW'(100); pulse_w = PW'(4); holdoff = '0;
    trig_in = 1'b1;
    wait_strobe("abort");
    cycle();
    run(49);
    enable = 1'b0;
    cycle();
    check("abort_busy", int'(busy), 0);
    enable = 1'b1;
    run(80);
    trig_in = 1'b0;
    run(10);

    // Edge while disabled is not acted on after re-enable
    enable  = 1'b0;
    trig_in = 1'b1;
    run(12);
    enable = 1'b1;
    run(20);
    check("disabled_edge_busy", int'(busy), 0);
    trig_in = 1'b0;
    run(10);

    // Delay changed mid-flight keeps the latched 100
    trig_in = 1'b1;
    wait_strobe("latch");
    cycle();
    delay = DW'(7);
    run(120);
    trig_in = 1'b0;
    run(10);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        trig_in = ~trig_in;
        hold    = int'($urandom_range(1, 12));
      end
      hold--;
      if ($urandom_range(0, 99) < 5) edge_mode = 2'($urandom_range(0, 3));
      delay   = DW'($urandom_range(0, 20));
      pulse_w = PW'($urandom_range(0, 6));
      holdoff = DW'($urandom_range(0, 15));
      enable  = ($urandom_range(0, 99) >= 2);
      cnt_clr = ($urandom_range(0, 99) == 0);
      cycle();
    end
    enable  = 1'b1;
    cnt_clr = 1'b0;
    run(100);
    check("pulses_drained", pulse_q.size(), 0);

    // Asynchronous reset during a pulse
    edge_mode = 2'b00; delay = DW'(2); pulse_w = PW'(20); holdoff = '0;
    trig_in = 1'b0;
    run(10);
    trig_in = 1'b1;
    wait_strobe("rst");
    cycle();
    run(4);
    check("pre_rst_trig_recv", int'(trig_recv), 1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_trig_recv", int'(trig_recv), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_trig_cnt", int'(trig_cnt), 0);
    check("async_rst_miss_cnt", int'(miss_cnt), 0);
    @(posedge clk);
    #1;
    check("held_rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ext_trig_gen.md
EXT_TRIG_GEN -- requirements
Module: ext_trig_gen

Interface
REQ-001 Parameters SHALL be: DELAY_W, default 16, width of the delay and holdoff fields.
REQ-002 Parameters SHALL include: PULSE_W, default 8, width of the pulse-width field.
REQ-003 Parameters SHALL include: FILT_LEN, default 4, number of consecutive stable cycles required to accept a level change.
REQ-004 Parameters SHALL include: CNT_W, default 16, width of the trigger and miss counters.
REQ-005 Ports SHALL be:
- i_clk100M  in  1  100 MHz clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_trig_in  in  1  asynchronous external trigger.
- i_enable  in  1  arm; low aborts activity.
- i_edge_mode  in  2  00 rising, 01 falling, 10 both, 11 none.
- i_delay  in  DELAY_W  delay from edge to pulse, in 10 ns units.
- i_pulse_w  in  PULSE_W  output pulse width, in 10 ns units.
- i_holdoff  in  DELAY_W  re-arm dead time after the pulse, in 10 ns units.
- i_cnt_clr  in  1  synchronous clear of both counters.
- o_trig_recv  out  1  delayed trigger pulse.
- o_busy  out  1  high in any state except IDLE.
- o_trig_cnt  out  CNT_W  accepted triggers.
- o_miss_cnt  out  CNT_W  edges ignored while busy.

Function
REQ-006 Input path SHALL be a 2-flop synchroniser followed by a glitch filter.
REQ-007 The filtered level SHALL take the synchronised value only after that value has been stable for FILT_LEN consecutive cycles.
REQ-008 The filtered level SHALL reset to 0.
REQ-009 Edge detect SHALL act on the filtered level and give one qualified-edge cycle per mode match; mode 11 SHALL give none.
REQ-010 States SHALL be IDLE, DELAY, PULSE and HOLDOFF, one-hot encoded.
REQ-011 IDLE -> DELAY SHALL occur on a qualified edge when i_enable=1.
REQ-012 On that IDLE -> DELAY transition, the block SHALL latch D=i_delay, P=i_pulse_w and H=i_holdoff.
REQ-013 Configuration changes after the latch SHALL NOT affect the trigger in flight.
REQ-014 o_trig_recv SHALL rise max(D,1) cycles after the qualified-edge cycle; D=0 and D=1 are identical.
REQ-015 o_trig_recv SHALL stay high for exactly max(P,1) cycles, then the block SHALL enter HOLDOFF.
REQ-016 HOLDOFF SHALL last H cycles; H=0 SHALL return to IDLE in the cycle after the pulse ends.
REQ-017 A new qualified edge SHALL be accepted in the first IDLE cycle.
REQ-018 o_trig_cnt SHALL increment once per IDLE -> DELAY transition.
REQ-019 o_miss_cnt SHALL increment once per qualified edge seen in DELAY, PULSE or HOLDOFF.
REQ-020 Both counters SHALL saturate at all-ones with no wrap.
REQ-021 i_cnt_clr SHALL zero both counters next cycle and SHALL override a simultaneous increment.
REQ-022 i_enable=0 in any state SHALL force IDLE and o_trig_recv=0 on the next clock, and edges while disabled SHALL NOT count.
REQ-023 Re-enable SHALL NOT act on an edge that occurred while disabled.
REQ-024 o_trig_recv SHALL be driven directly from a flop.
REQ-025 Delay, pulse and holdoff counters SHALL decrement, and their terminal tests SHALL compare against 1 or 0 only.

Reset
REQ-026 While i_rst_n=0, all of the following SHALL hold: state=IDLE, o_trig_recv=0, o_busy=0, counters=0, synchroniser and filter flops=0, latched D, P and H=0.
REQ-027 Reset mid-pulse SHALL drop o_trig_recv immediately (asynchronously).
REQ-028 After reset release, the first edge SHALL require a full FILT_LEN qualification.

Structure
REQ-029 Package trig_pkg SHALL hold the state one-hot constants and the i_edge_mode encodings (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_NONE).
REQ-030 Sub-module trig_filter SHALL contain the synchroniser, glitch filter and edge detect.
REQ-031 trig_filter SHALL be parameterised by FILT_LEN and SHALL output rise/fall strobes.
REQ-032 ext_trig_gen SHALL contain the FSM, the timers and the counters.

Verification
REQ-033 Rising mode, D=5, P=3, H=0, clean 0->1 step on i_trig_in: o_trig_recv SHALL go high exactly 5 cycles after the edge strobe and stay high 3 cycles; o_trig_cnt=1.
REQ-034 FILT_LEN=4, 3-cycle high glitch on i_trig_in: no strobe, no pulse, both counters unchanged.
REQ-035 Both-edge mode, D=0, P=1, H=10, i_trig_in toggled every 4 cycles: the first edge SHALL give a 1-cycle pulse 1 cycle after the strobe, and edges inside DELAY, PULSE and HOLDOFF SHALL increment o_miss_cnt.
REQ-036 CNT_W=4, 20 spaced triggers: o_trig_cnt SHALL hold at 15; then i_cnt_clr asserted together with a new accept SHALL give 0.
REQ-037 D=100, i_enable dropped at edge+50: o_busy SHALL go low next cycle and no pulse SHALL occur; i_delay changed to 7 mid-delay in a separate run SHALL still give a 100-cycle delay.
REQ-038 Asynchronous reset asserted during PULSE: o_trig_recv SHALL be 0 at once and all outputs at reset values.
